mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and byte-wide memory bus shared by mem_arbiter and its requesters.
// Channel i occupies slice i of each flattened request bus.
interface mem_arbiter_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned LenW = $clog2(DATA_W / 8) + 1;

  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_wr;
  logic [NCH-1:0]        req_signed;
  logic [NCH*LenW-1:0]   req_len;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH*DATA_W-1:0] req_wdata;
  logic [NCH-1:0]        req_ack;
  logic [NCH-1:0]        resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wr;

  modport slave (
    input  req_valid, req_wr, req_signed, req_len, req_addr, req_wdata, mem_din,
    output req_ack, resp_valid, resp_rdata, mem_dout, mem_addr, mem_wr
  );

  modport master (
    output req_valid, req_wr, req_signed, req_len, req_addr, req_wdata, mem_din,
    input  req_ack, resp_valid, resp_rdata, mem_dout, mem_addr, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter that serialises word-sized reads/writes onto a byte-wide memory bus.
// Fixed-priority or round-robin grant; each transaction runs to completion without preemption.
module mem_arbiter #(
  parameter int unsigned       NCH      = 2,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       RD_LAT   = 1,
  parameter int unsigned       ARB_MODE = 0,
  parameter logic [ADDR_W-1:0] IO_BASE  = 'h30000
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  input logic          clr_in,
  input logic          io_buffer_full,
  mem_arbiter_if.slave bus
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LEN_W = $clog2(BYTES) + 1;
  localparam int unsigned KW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned TW    = $clog2(BYTES + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d, grant_q, grant_d, win;
  logic                    win_found;
  logic [NCH-1:0]          elig, ack_q, ack_d, rv_q, rv_d;
  logic [ADDR_W-1:0]       base_q, base_d, maddr_q, maddr_d, sel_addr;
  logic [LEN_W-1:0]        len_q, len_d, sel_len;
  logic [TW-1:0]           t_q, t_d, t_next;
  logic                    sgn_q, sgn_d, wr_q, wr_d, sel_wr, sel_sgn;
  logic [7:0]              dout_q, dout_d;
  logic [DATA_W-1:0]       sel_wdata;
  logic [BYTES-1:0][7:0]   wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic [KW-1:0]           kb, lastb;

  // An IO-space write is held off while the IO buffer is full; checked only at arbitration.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      elig[i] = bus.req_valid[i] &
                ~(bus.req_wr[i] & (bus.req_addr[i*ADDR_W +: ADDR_W] >= IO_BASE) & io_buffer_full);
    end
  end

  // Two passes: channels at/after the pointer first, then wrap to those below it.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!win_found && elig[c] && (c >= int'(ptr_q))) begin
        win_found = 1'b1;
        win       = PW'(c);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (!win_found && elig[c]) begin
        win_found = 1'b1;
        win       = PW'(c);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    sel_sgn   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (PW'(c) == win) begin
        sel_addr  = bus.req_addr[c*ADDR_W +: ADDR_W];
        sel_len   = bus.req_len[c*LEN_W +: LEN_W];
        sel_wdata = bus.req_wdata[c*DATA_W +: DATA_W];
        sel_wr    = bus.req_wr[c];
        sel_sgn   = bus.req_signed[c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    rv_d    = rv_q;
    base_d  = base_q;
    maddr_d = maddr_q;
    len_d   = len_q;
    t_d     = t_q;
    sgn_d   = sgn_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    t_next  = t_q + 1'b1;
    kb      = KW'(t_next - TW'(RD_LAT));
    lastb   = KW'(len_q - 1'b1);

    if (clr_in) begin
      state_d = StIdle;
      wr_d    = 1'b0;
      ack_d   = '0;
      rv_d    = '0;
      ptr_d   = '0;
    end else if (rdy_in) begin
      ack_d = '0;
      rv_d  = '0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_d = win;
            ack_d   = NCH'(1) << win;
            base_d  = sel_addr;
            maddr_d = sel_addr;
            sgn_d   = sel_sgn;
            wdata_d = sel_wdata;
            t_d     = '0;
            if (sel_len == '0)                    len_d = LEN_W'(1);
            else if (sel_len > LEN_W'(BYTES))     len_d = LEN_W'(BYTES);
            else                                  len_d = sel_len;
            if (ARB_MODE == 1) ptr_d = (win == PW'(NCH - 1)) ? '0 : win + 1'b1;
            if (sel_wr) begin
              wr_d    = 1'b1;
              dout_d  = sel_wdata[7:0];
              state_d = StWrite;
            end else begin
              state_d = StRead;
            end
          end
        end
        StRead: begin
          t_d = t_next;
          if (t_next < TW'(len_q)) maddr_d = base_q + ADDR_W'(t_next);
          if (t_next >= TW'(RD_LAT)) rbuf_d[kb] = bus.mem_din;
          if (t_next == TW'(len_q) + TW'(RD_LAT - 1)) begin
            for (int b = 0; b < BYTES; b++) begin
              rdata_d[b] = (b < int'(len_q)) ? rbuf_d[b] : {8{sgn_q & rbuf_d[lastb][7]}};
            end
            rv_d    = NCH'(1) << grant_q;
            state_d = StIdle;
          end
        end
        StWrite: begin
          t_d = t_next;
          if (t_next < TW'(len_q)) begin
            maddr_d = base_q + ADDR_W'(t_next);
            dout_d  = wdata_q[KW'(t_next)];
          end else begin
            wr_d    = 1'b0;
            rv_d    = NCH'(1) << grant_q;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      base_q  <= '0;
      maddr_q <= '0;
      len_q   <= '0;
      t_q     <= '0;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      base_q  <= base_d;
      maddr_q <= maddr_d;
      len_q   <= len_d;
      t_q     <= t_d;
      sgn_q   <= sgn_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wr     = wr_q & rdy_in;
endmodule
